// File: rtl/pktctrl_pkg.sv
// Shared types and constants for the packet-control framing path.
// Holds the beat widths, the FSM state type and the payload length decode.
package pktctrl_pkg;

  localparam int DW   = 36;
  localparam int BW   = 18;
  localparam int SEQW = 16;

  localparam logic [1:0] HDR_TAG = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    GAP     = 2'd3
  } state_e;

  // 2-bit length code -> payload beat count (always even, max 512).
  function automatic logic [9:0] len_beats(input logic [1:0] code);
    logic [9:0] beats;
    case (code)
      2'd0:    beats = 10'd64;
      2'd1:    beats = 10'd128;
      2'd2:    beats = 10'd256;
      default: beats = 10'd512;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/pkt_gap_timer.sv
// Load/decrement counter timing the idle gap between packets.
// done is high while the count is on its final cycle (or already spent).
module pkt_gap_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q <= W'(1));

endmodule

// File: rtl/pkt_tx_framer.sv
// Packet framer: header beat, split buffer-word or counter payload, idle gap.
// Turns 36-bit buffer words into the registered 18-bit ADC_DATA beat stream.
module pkt_tx_framer #(
  parameter int DW   = pktctrl_pkg::DW,
  parameter int BW   = pktctrl_pkg::BW,
  parameter int SEQW = pktctrl_pkg::SEQW
) (
  input  logic            pktctrl_clk,
  input  logic            pktctrl_rst,
  input  logic            rf_capture_start,
  input  logic            rf_self_test_mode,
  input  logic [1:0]      rf_pkt_data_length,
  input  logic [15:0]     rf_pkt_idle_length,
  input  logic [DW-1:0]   buf_rdata,
  input  logic            buf_rvalid,
  output logic            buf_rready,
  input  logic            underflow_clr,
  output logic [BW-1:0]   ADC_DATA,
  output logic            ADC_DATA_VALID,
  output logic            pkt_busy,
  output logic            underflow_sticky,
  output logic [SEQW-1:0] pkt_seq
);
  import pktctrl_pkg::*;

  state_e          state_q, state_d;
  logic            phase_q, phase_d;
  logic [9:0]      beat_q, beat_d;
  logic [9:0]      len_q, len_d;
  logic            st_q, st_d;
  logic [BW-1:0]   hold_q, hold_d;
  logic [SEQW-1:0] seq_q, seq_d;
  logic            uf_q, uf_d;
  logic [BW-1:0]   adc_data_q, adc_data_d;
  logic            adc_valid_q, adc_valid_d;

  logic beat_adv;
  logic last_beat;
  logic uf_set;
  logic gap_done;

  // A payload beat advances unless a normal-mode phase0 finds the buffer empty.
  assign beat_adv  = st_q || phase_q || buf_rvalid;
  assign last_beat = (state_q == PAYLOAD) && beat_adv && (beat_q == len_q - 10'd1);

  pkt_gap_timer #(.W(16)) u_gap_timer (
    .clk      (pktctrl_clk),
    .rst      (pktctrl_rst),
    .load     (last_beat),
    .dec      (state_q == GAP),
    .load_val (rf_pkt_idle_length),
    .done     (gap_done)
  );

  always_ff @(posedge pktctrl_clk or posedge pktctrl_rst) begin
    if (pktctrl_rst) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      beat_q      <= '0;
      len_q       <= '0;
      st_q        <= 1'b0;
      hold_q      <= '0;
      seq_q       <= '0;
      uf_q        <= 1'b0;
      adc_data_q  <= '0;
      adc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      beat_q      <= beat_d;
      len_q       <= len_d;
      st_q        <= st_d;
      hold_q      <= hold_d;
      seq_q       <= seq_d;
      uf_q        <= uf_d;
      adc_data_q  <= adc_data_d;
      adc_valid_q <= adc_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rf_capture_start) state_d = HDR;
      HDR:     state_d = PAYLOAD;
      PAYLOAD: begin
        if (last_beat) begin
          if (rf_pkt_idle_length != 16'd0) state_d = GAP;
          else                             state_d = rf_capture_start ? HDR : IDLE;
        end
      end
      GAP:     if (gap_done) state_d = rf_capture_start ? HDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    phase_d     = phase_q;
    beat_d      = beat_q;
    len_d       = len_q;
    st_d        = st_q;
    hold_d      = hold_q;
    seq_d       = seq_q;
    adc_data_d  = adc_data_q;
    adc_valid_d = 1'b0;
    buf_rready  = 1'b0;
    uf_set      = 1'b0;
    case (state_q)
      HDR: begin
        adc_data_d  = {HDR_TAG, seq_q};
        adc_valid_d = 1'b1;
        len_d       = len_beats(rf_pkt_data_length);
        st_d        = rf_self_test_mode;
        beat_d      = '0;
        phase_d     = 1'b0;
      end
      PAYLOAD: begin
        if (st_q) begin
          adc_data_d  = BW'(beat_q);
          adc_valid_d = 1'b1;
          beat_d      = beat_q + 10'd1;
        end else if (phase_q) begin
          adc_data_d  = hold_q;
          adc_valid_d = 1'b1;
          phase_d     = 1'b0;
          beat_d      = beat_q + 10'd1;
        end else if (buf_rvalid) begin
          buf_rready  = 1'b1;
          hold_d      = buf_rdata[DW-1:BW];
          adc_data_d  = buf_rdata[BW-1:0];
          adc_valid_d = 1'b1;
          phase_d     = 1'b1;
          beat_d      = beat_q + 10'd1;
        end else begin
          uf_set = 1'b1;
        end
        if (last_beat) seq_d = seq_q + SEQW'(1);
      end
      default: adc_data_d = '0;
    endcase
    uf_d = uf_set ? 1'b1 : (underflow_clr ? 1'b0 : uf_q);
  end

  assign ADC_DATA         = adc_data_q;
  assign ADC_DATA_VALID   = adc_valid_q;
  assign pkt_busy         = (state_q != IDLE);
  assign underflow_sticky = uf_q;
  assign pkt_seq          = seq_q;

endmodule

// File: tb/tb_pkt_tx_framer.sv
// Self-checking bench for pkt_tx_framer: random buffer stalls and configs,
// checked by a packet-level monitor that knows only the word stream it supplied.
module tb_pkt_tx_framer;

  logic        pktctrl_clk = 1'b0;
  logic        pktctrl_rst = 1'b1;
  logic        rf_capture_start = 1'b0;
  logic        rf_self_test_mode = 1'b0;
  logic [1:0]  rf_pkt_data_length = 2'd0;
  logic [15:0] rf_pkt_idle_length = 16'd0;
  logic [35:0] buf_rdata = 36'd0;
  logic        buf_rvalid = 1'b0;
  logic        buf_rready;
  logic        underflow_clr = 1'b0;
  logic [17:0] ADC_DATA;
  logic        ADC_DATA_VALID;
  logic        pkt_busy;
  logic        underflow_sticky;
  logic [15:0] pkt_seq;

  pkt_tx_framer dut (
    .pktctrl_clk        (pktctrl_clk),
    .pktctrl_rst        (pktctrl_rst),
    .rf_capture_start   (rf_capture_start),
    .rf_self_test_mode  (rf_self_test_mode),
    .rf_pkt_data_length (rf_pkt_data_length),
    .rf_pkt_idle_length (rf_pkt_idle_length),
    .buf_rdata          (buf_rdata),
    .buf_rvalid         (buf_rvalid),
    .buf_rready         (buf_rready),
    .underflow_clr      (underflow_clr),
    .ADC_DATA           (ADC_DATA),
    .ADC_DATA_VALID     (ADC_DATA_VALID),
    .pkt_busy           (pkt_busy),
    .underflow_sticky   (underflow_sticky),
    .pkt_seq            (pkt_seq)
  );

  initial forever #5 pktctrl_clk = ~pktctrl_clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Buffer content the bench offers, in order; the source advances on each handshake.
  logic [35:0] words [0:8191];
  int unsigned src_idx = 0;
  bit          stall_mode = 1'b0;
  bit          mon_en = 1'b0;

  initial forever begin
    @(posedge pktctrl_clk);
    #1;
    buf_rdata  = words[src_idx % 8192];
    buf_rvalid = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Packet-level reference: header, then 64<<len beats, then idle_length blank beats.
  int unsigned word_ptr = 0;
  int unsigned beat = 0;
  int unsigned gap_cnt = 0;
  int unsigned hs = 0;
  int unsigned pkt_count = 0;
  int unsigned stall_total = 0;
  int unsigned pkt_stalls = 0;
  int unsigned plen;
  bit          in_pay = 1'b0;
  bit          first = 1'b1;
  bit          hsk;
  logic [15:0] exp_seq = 16'd0;
  logic [17:0] last_data = 18'd0;
  logic [17:0] exp_beat;

  always @(negedge pktctrl_clk) begin
    if (pktctrl_rst) begin
      in_pay   = 1'b0;
      first    = 1'b1;
      exp_seq  = 16'd0;
      word_ptr = src_idx;
    end else begin
      hsk  = buf_rvalid && buf_rready;
      plen = 64 << rf_pkt_data_length;
      check_eq("rready_needs_rvalid", 36'(buf_rready & ~buf_rvalid), 36'd0);
      if (hsk) src_idx++;
      if (!mon_en) begin
        in_pay = 1'b0;
        first  = 1'b1;
      end else if (!in_pay) begin
        if (ADC_DATA_VALID) begin
          check_eq("header", 36'(ADC_DATA), 36'({2'b10, exp_seq}));
          if (!first) check_eq("gap_len", 36'(gap_cnt), 36'(rf_pkt_idle_length));
          first      = 1'b0;
          in_pay     = 1'b1;
          beat       = 0;
          pkt_stalls = 0;
          hs         = hsk ? 1 : 0;
        end else begin
          gap_cnt++;
          check_eq("rready_outside_payload", 36'(buf_rready), 36'd0);
        end
      end else begin
        if (hsk) hs++;
        if (ADC_DATA_VALID) begin
          if (rf_self_test_mode) begin
            exp_beat = 18'(beat);
          end else if (beat % 2 == 0) begin
            exp_beat = words[word_ptr % 8192][17:0];
          end else begin
            exp_beat = words[word_ptr % 8192][35:18];
            word_ptr++;
          end
          check_eq("payload", 36'(ADC_DATA), 36'(exp_beat));
          beat++;
          if (beat == plen) begin
            check_eq("rready_count", 36'(hs), rf_self_test_mode ? 36'd0 : 36'(plen / 2));
            if (rf_self_test_mode) check_eq("selftest_stalls", 36'(pkt_stalls), 36'd0);
            $display("pkt seq=0x%04h len=%0d st=%0d stalls=%0d", exp_seq, plen,
                     rf_self_test_mode, pkt_stalls);
            exp_seq = exp_seq + 16'd1;
            pkt_count++;
            gap_cnt = 0;
            in_pay  = 1'b0;
          end
        end else begin
          check_eq("stall_hold", 36'(ADC_DATA), 36'(last_data));
          pkt_stalls++;
          if (!rf_self_test_mode) stall_total++;
        end
      end
    end
    last_data = ADC_DATA;
  end

  task automatic wait_pkts(input int unsigned n, input int budget);
    int unsigned tgt;
    tgt = pkt_count + n;
    for (int i = 0; i < budget && pkt_count < tgt; i++) begin
      @(negedge pktctrl_clk);
      #1;
    end
    check_eq("pkts_reached", 36'(pkt_count >= tgt), 36'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && pkt_busy; i++) begin
      @(negedge pktctrl_clk);
      #1;
    end
    check_eq("busy_after_stop", 36'(pkt_busy), 36'd0);
  endtask

  task automatic finish_scn(input int unsigned stall_snap);
    rf_capture_start = 1'b0;
    wait_idle(3000);
    check_eq("stop_gap", 36'(gap_cnt), 36'(rf_pkt_idle_length));
    check_eq("pkt_seq", 36'(pkt_seq), 36'(exp_seq));
    check_eq("underflow", 36'(underflow_sticky), 36'(stall_total != stall_snap));
    stall_mode = 1'b0;
    @(posedge pktctrl_clk);
    #1;
    underflow_clr = 1'b1;
    @(posedge pktctrl_clk);
    #1;
    underflow_clr = 1'b0;
    @(negedge pktctrl_clk);
    check_eq("underflow_cleared", 36'(underflow_sticky), 36'd0);
    mon_en = 1'b0;
    @(negedge pktctrl_clk);
  endtask

  task automatic run_scn(input bit st, input logic [1:0] len, input logic [15:0] idle,
                         input bit stall, input int unsigned npk);
    int unsigned snap;
    snap               = stall_total;
    rf_self_test_mode  = st;
    rf_pkt_data_length = len;
    rf_pkt_idle_length = idle;
    stall_mode         = stall;
    mon_en             = 1'b1;
    rf_capture_start   = 1'b1;
    wait_pkts(npk, 4000);
    finish_scn(snap);
  endtask

  initial begin
    int unsigned snap;
    for (int i = 0; i < 8192; i++) begin
      words[i] = (i < 256) ? 36'(i + 1) : {4'($urandom), $urandom};
    end
    repeat (3) @(posedge pktctrl_clk);
    #1;
    check_eq("rst_adc_data", 36'(ADC_DATA), 36'd0);
    check_eq("rst_valid", 36'(ADC_DATA_VALID), 36'd0);
    check_eq("rst_rready", 36'(buf_rready), 36'd0);
    check_eq("rst_busy", 36'(pkt_busy), 36'd0);
    check_eq("rst_underflow", 36'(underflow_sticky), 36'd0);
    check_eq("rst_seq", 36'(pkt_seq), 36'd0);
    pktctrl_rst = 1'b0;
    @(negedge pktctrl_clk);

    run_scn(1'b1, 2'd0, 16'd4, 1'b0, 2);
    run_scn(1'b0, 2'd0, 16'd3, 1'b0, 3);
    run_scn(1'b0, 2'd0, 16'd2, 1'b1, 3);
    run_scn(1'b1, 2'd3, 16'd0, 1'b0, 3);
    run_scn(1'b0, 2'd3, 16'd0, 1'b1, 2);

    // Drop start during beat 5: that packet and its gap must still complete.
    snap               = stall_total;
    rf_self_test_mode  = 1'b0;
    rf_pkt_data_length = 2'd1;
    rf_pkt_idle_length = 16'd5;
    stall_mode         = 1'b1;
    mon_en             = 1'b1;
    rf_capture_start   = 1'b1;
    for (int i = 0; i < 2000 && !(in_pay && beat == 5); i++) begin
      @(negedge pktctrl_clk);
      #1;
    end
    check_eq("reached_beat5", 36'(in_pay && beat == 5), 36'd1);
    begin
      int unsigned tgt;
      tgt = pkt_count + 1;
      rf_capture_start = 1'b0;
      wait_idle(2000);
      check_eq("full_pkt_after_stop", 36'(pkt_count), 36'(tgt));
    end
    finish_scn(snap);

    for (int r = 0; r < 5; r++) begin
      run_scn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)),
              16'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 2);
    end

    // Asynchronous reset in the middle of a payload.
    snap               = stall_total;
    rf_self_test_mode  = 1'b0;
    rf_pkt_data_length = 2'd1;
    rf_pkt_idle_length = 16'd2;
    stall_mode         = 1'b1;
    mon_en             = 1'b1;
    rf_capture_start   = 1'b1;
    for (int i = 0; i < 2000 && !(in_pay && beat == 20); i++) begin
      @(negedge pktctrl_clk);
      #1;
    end
    check_eq("reached_beat20", 36'(in_pay && beat == 20), 36'd1);
    @(posedge pktctrl_clk);
    #2;
    pktctrl_rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 36'(ADC_DATA_VALID), 36'd0);
    check_eq("async_rst_seq", 36'(pkt_seq), 36'd0);
    check_eq("async_rst_busy", 36'(pkt_busy), 36'd0);
    repeat (2) @(posedge pktctrl_clk);
    #1;
    pktctrl_rst = 1'b0;
    snap = stall_total;
    wait_pkts(2, 4000);
    finish_scn(snap);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
